ysyx_040750_csr_regfile: RTL and testbench

//  Machine-mode CSR register file directly downstream of the CSR ALU: holds mstatus, mtvec, mepc,

---
 rtl/ysyx_040750_csr_regfile_if.sv | 29 ++
 rtl/ysyx_040750_csr_regfile.sv | 103 ++++++++++
 tb/tb_ysyx_040750_csr_regfile.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_040750_csr_regfile_if.sv
// Bus between the write-back stage and the machine-mode CSR register file:
// ALU operand read, result commit, ecall/mret retirement and the fetch redirect.
interface ysyx_040750_csr_regfile_if #(
    parameter int XLEN = 64
);
    logic [11:0]     I_csr_raddr;
    logic [XLEN-1:0] O_csr_rdata;
    logic            O_csr_illegal;
    logic            I_csr_wen;
    logic [11:0]     I_csr_waddr;
    logic [XLEN-1:0] I_csr_wdata;
    logic            I_ecall;
    logic            I_mret;
    logic [XLEN-1:0] I_pc;
    logic            O_redirect_valid;
    logic [XLEN-1:0] O_redirect_pc;

    modport master (
        output I_csr_raddr, I_csr_wen, I_csr_waddr, I_csr_wdata,
        output I_ecall, I_mret, I_pc,
        input  O_csr_rdata, O_csr_illegal, O_redirect_valid, O_redirect_pc
    );

    modport slave (
        input  I_csr_raddr, I_csr_wen, I_csr_waddr, I_csr_wdata,
        input  I_ecall, I_mret, I_pc,
        output O_csr_rdata, O_csr_illegal, O_redirect_valid, O_redirect_pc
    );
endinterface

// File: rtl/ysyx_040750_csr_regfile.sv
// Machine-mode CSR file: mstatus/mtvec/mepc/mcause/mcycle with combinational read,
// single commit per cycle, ecall trap entry, mret return and a registered fetch redirect.
module ysyx_040750_csr_regfile #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RST   = '0,
    parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(64'h1800)
) (
    input  logic                      I_sys_clk,
    input  logic                      I_rst,
    ysyx_040750_csr_regfile_if.slave  csr
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(11);

    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mcycle;
    logic            redirect_vld_p1;
    logic [XLEN-1:0] redirect_pc_p1;

    // MPIE <= MIE, MIE <= 0, MPP <= M
    function automatic logic [XLEN-1:0] mstatus_trap(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r         = s;
        r[7]      = s[3];
        r[3]      = 1'b0;
        r[12:11]  = 2'b11;
        return r;
    endfunction

    // MIE <= MPIE, MPIE <= 1, MPP stays M (only M-mode exists)
    function automatic logic [XLEN-1:0] mstatus_ret(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r         = s;
        r[3]      = s[7];
        r[7]      = 1'b1;
        r[12:11]  = 2'b11;
        return r;
    endfunction

    logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause, wr_mcycle;
    assign wr_mstatus = csr.I_csr_wen && (csr.I_csr_waddr == ADDR_MSTATUS);
    assign wr_mtvec   = csr.I_csr_wen && (csr.I_csr_waddr == ADDR_MTVEC);
    assign wr_mepc    = csr.I_csr_wen && (csr.I_csr_waddr == ADDR_MEPC);
    assign wr_mcause  = csr.I_csr_wen && (csr.I_csr_waddr == ADDR_MCAUSE);
    assign wr_mcycle  = csr.I_csr_wen && (csr.I_csr_waddr == ADDR_MCYCLE);

    // Read side: no bypass of same-cycle commits; the pipeline forwards around this.
    always_comb begin
        csr.O_csr_rdata   = '0;
        csr.O_csr_illegal = 1'b0;
        unique case (csr.I_csr_raddr)
            ADDR_MSTATUS: csr.O_csr_rdata = mstatus;
            ADDR_MTVEC:   csr.O_csr_rdata = mtvec;
            ADDR_MEPC:    csr.O_csr_rdata = mepc;
            ADDR_MCAUSE:  csr.O_csr_rdata = mcause;
            ADDR_MCYCLE:  csr.O_csr_rdata = mcycle;
            default:      csr.O_csr_illegal = 1'b1;
        endcase
    end

    // Commit stage -> redirect register (p1)
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            mstatus         <= MSTATUS_RST;
            mtvec           <= MTVEC_RST;
            mepc            <= '0;
            mcause          <= '0;
            mcycle          <= '0;
            redirect_vld_p1 <= 1'b0;
            redirect_pc_p1  <= '0;
        end else begin
            mcycle          <= wr_mcycle ? csr.I_csr_wdata : mcycle + 1'b1;
            redirect_vld_p1 <= csr.I_ecall || csr.I_mret;
            if (wr_mtvec)
                mtvec <= {csr.I_csr_wdata[XLEN-1:2], 2'b00};
            // Trap state owned by ecall/mret wins over a concurrent software write.
            if (csr.I_ecall) begin
                mepc           <= csr.I_pc;
                mcause         <= CAUSE_ECALL_M;
                mstatus        <= mstatus_trap(mstatus);
                redirect_pc_p1 <= mtvec;
            end else if (csr.I_mret) begin
                mstatus        <= mstatus_ret(mstatus);
                redirect_pc_p1 <= mepc;
            end else begin
                if (wr_mstatus) mstatus <= csr.I_csr_wdata;
                if (wr_mepc)    mepc    <= csr.I_csr_wdata;
                if (wr_mcause)  mcause  <= csr.I_csr_wdata;
            end
        end
    end

    assign csr.O_redirect_valid = redirect_vld_p1;
    assign csr.O_redirect_pc    = redirect_pc_p1;

endmodule

// File: tb/tb_ysyx_040750_csr_regfile.sv
// Scenario bench for the machine-mode CSR register file; expected reads are queued
// as stimulus is applied and drained against the DUT after the relevant edge.
module tb_ysyx_040750_csr_regfile;
    logic I_sys_clk = 1'b0;
    logic I_rst;

    ysyx_040750_csr_regfile_if #(.XLEN(64)) csr ();

    ysyx_040750_csr_regfile dut (
        .I_sys_clk (I_sys_clk),
        .I_rst     (I_rst),
        .csr       (csr)
    );

    always #5 I_sys_clk = ~I_sys_clk;

    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
        logic        ill;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge I_sys_clk);
        #1;
    endtask

    task automatic idle();
        csr.I_csr_wen   = 1'b0;
        csr.I_csr_waddr = '0;
        csr.I_csr_wdata = '0;
        csr.I_ecall     = 1'b0;
        csr.I_mret      = 1'b0;
        csr.I_pc        = '0;
        csr.I_csr_raddr = 12'h300;
    endtask

    task automatic test_reset();
        rd_exp_t e;
        I_rst = 1'b1;
        idle();
        csr.I_ecall = 1'b1;
        csr.I_pc    = 64'hDEAD_0000;
        tick();
        tick();
        I_rst = 1'b0;
        idle();
        exp_q.push_back('{12'h300, 64'h1800, 1'b0});
        exp_q.push_back('{12'h305, 64'h0, 1'b0});
        exp_q.push_back('{12'h341, 64'h0, 1'b0});
        exp_q.push_back('{12'h342, 64'h0, 1'b0});
        exp_q.push_back('{12'hB00, 64'h0, 1'b0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.I_csr_raddr = e.addr;
            #1;
            total++;
            if (csr.O_csr_rdata !== e.data || csr.O_csr_illegal !== e.ill) begin
                $display("FAIL reset_rd[%h] got %h/%b want %h/%b", e.addr, csr.O_csr_rdata, csr.O_csr_illegal, e.data, e.ill);
                bad++;
            end
        end
        total++;
        if (csr.O_redirect_valid !== 1'b0 || csr.O_redirect_pc !== 64'h0) begin
            $display("FAIL reset_redirect got %b/%h want 0/0", csr.O_redirect_valid, csr.O_redirect_pc);
            bad++;
        end
    endtask

    task automatic test_mtvec_write();
        rd_exp_t e;
        csr.I_csr_wen   = 1'b1;
        csr.I_csr_waddr = 12'h305;
        csr.I_csr_wdata = 64'h8000_0103;
        csr.I_csr_raddr = 12'h305;
        #1;
        total++;
        if (csr.O_csr_rdata !== 64'h0) begin
            $display("FAIL mtvec_same_cycle got %h want %h", csr.O_csr_rdata, 64'h0);
            bad++;
        end
        exp_q.push_back('{12'h305, 64'h8000_0100, 1'b0});
        tick();
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.I_csr_raddr = e.addr;
            #1;
            total++;
            if (csr.O_csr_rdata !== e.data) begin
                $display("FAIL mtvec_rd[%h] got %h want %h", e.addr, csr.O_csr_rdata, e.data);
                bad++;
            end
        end
    endtask

    task automatic test_ecall();
        rd_exp_t e;
        csr.I_csr_wen   = 1'b1;
        csr.I_csr_waddr = 12'h300;
        csr.I_csr_wdata = 64'h1808;
        tick();
        idle();
        csr.I_ecall = 1'b1;
        csr.I_pc    = 64'h8000_0010;
        exp_q.push_back('{12'h341, 64'h8000_0010, 1'b0});
        exp_q.push_back('{12'h342, 64'd11, 1'b0});
        exp_q.push_back('{12'h300, 64'h1880, 1'b0});
        #1;
        total++;
        if (csr.O_redirect_valid !== 1'b0) begin
            $display("FAIL ecall_pre_valid got %b want 0", csr.O_redirect_valid);
            bad++;
        end
        tick();
        idle();
        total++;
        if (csr.O_redirect_valid !== 1'b1 || csr.O_redirect_pc !== 64'h8000_0100) begin
            $display("FAIL ecall_redirect got %b/%h want 1/%h", csr.O_redirect_valid, csr.O_redirect_pc, 64'h8000_0100);
            bad++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.I_csr_raddr = e.addr;
            #1;
            total++;
            if (csr.O_csr_rdata !== e.data) begin
                $display("FAIL ecall_rd[%h] got %h want %h", e.addr, csr.O_csr_rdata, e.data);
                bad++;
            end
        end
        tick();
        total++;
        if (csr.O_redirect_valid !== 1'b0) begin
            $display("FAIL ecall_pulse_end got %b want 0", csr.O_redirect_valid);
            bad++;
        end
    endtask

    task automatic test_mret();
        rd_exp_t e;
        csr.I_mret = 1'b1;
        csr.I_pc   = 64'h8000_0200;
        exp_q.push_back('{12'h300, 64'h1888, 1'b0});
        exp_q.push_back('{12'h341, 64'h8000_0010, 1'b0});
        tick();
        idle();
        total++;
        if (csr.O_redirect_valid !== 1'b1 || csr.O_redirect_pc !== 64'h8000_0010) begin
            $display("FAIL mret_redirect got %b/%h want 1/%h", csr.O_redirect_valid, csr.O_redirect_pc, 64'h8000_0010);
            bad++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.I_csr_raddr = e.addr;
            #1;
            total++;
            if (csr.O_csr_rdata !== e.data) begin
                $display("FAIL mret_rd[%h] got %h want %h", e.addr, csr.O_csr_rdata, e.data);
                bad++;
            end
        end
        tick();
        total++;
        if (csr.O_redirect_valid !== 1'b0) begin
            $display("FAIL mret_pulse_end got %b want 0", csr.O_redirect_valid);
            bad++;
        end
    endtask

    task automatic test_mcycle_wrap();
        logic [63:0] want;
        csr.I_csr_wen   = 1'b1;
        csr.I_csr_waddr = 12'hB00;
        csr.I_csr_wdata = '1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{12'hB00, 64'hFFFF_FFFF_FFFF_FFFF + 64'(i), 1'b0});
        tick();
        idle();
        csr.I_csr_raddr = 12'hB00;
        for (int i = 0; i < 3; i++) begin
            want = exp_q.pop_front().data;
            #1;
            total++;
            if (csr.O_csr_rdata !== want) begin
                $display("FAIL mcycle_wrap[%0d] got %h want %h", i, csr.O_csr_rdata, want);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_ecall_wen();
        rd_exp_t e;
        csr.I_ecall     = 1'b1;
        csr.I_pc        = 64'h8000_0300;
        csr.I_csr_wen   = 1'b1;
        csr.I_csr_waddr = 12'h341;
        csr.I_csr_wdata = 64'h1234;
        csr.I_csr_raddr = 12'h7C0;
        #1;
        total++;
        if (csr.O_csr_rdata !== 64'h0 || csr.O_csr_illegal !== 1'b1) begin
            $display("FAIL illegal_addr got %h/%b want 0/1", csr.O_csr_rdata, csr.O_csr_illegal);
            bad++;
        end
        exp_q.push_back('{12'h341, 64'h8000_0300, 1'b0});
        exp_q.push_back('{12'h300, 64'h1880, 1'b0});
        tick();
        // ecall with a concurrent mtvec write: the mtvec write must still commit
        csr.I_pc        = 64'h8000_0500;
        csr.I_csr_waddr = 12'h305;
        csr.I_csr_wdata = 64'h4000_0007;
        exp_q.push_back('{12'h305, 64'h4000_0004, 1'b0});
        exp_q.push_back('{12'h341, 64'h8000_0500, 1'b0});
        tick();
        idle();
        total++;
        if (csr.O_redirect_pc !== 64'h8000_0100) begin
            $display("FAIL ecall_wen_redirect got %h want %h", csr.O_redirect_pc, 64'h8000_0100);
            bad++;
        end
        e = exp_q.pop_front();
        e = exp_q.pop_front();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.I_csr_raddr = e.addr;
            #1;
            total++;
            if (csr.O_csr_rdata !== e.data) begin
                $display("FAIL ecall_wen_rd[%h] got %h want %h", e.addr, csr.O_csr_rdata, e.data);
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        csr.I_ecall = 1'b1;
        csr.I_pc    = 64'h8000_0400;
        tick();
        csr.I_ecall = 1'b0;
        csr.I_mret  = 1'b1;
        csr.I_pc    = 64'h8000_0404;
        total++;
        if (csr.O_redirect_valid !== 1'b1 || csr.O_redirect_pc !== 64'h4000_0004) begin
            $display("FAIL b2b_ecall got %b/%h want 1/%h", csr.O_redirect_valid, csr.O_redirect_pc, 64'h4000_0004);
            bad++;
        end
        tick();
        idle();
        total++;
        if (csr.O_redirect_valid !== 1'b1 || csr.O_redirect_pc !== 64'h8000_0400) begin
            $display("FAIL b2b_mret got %b/%h want 1/%h", csr.O_redirect_valid, csr.O_redirect_pc, 64'h8000_0400);
            bad++;
        end
        tick();
        total++;
        if (csr.O_redirect_valid !== 1'b0) begin
            $display("FAIL b2b_pulse_end got %b want 0", csr.O_redirect_valid);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_mtvec_write();
        test_ecall();
        test_mret();
        test_mcycle_wrap();
        test_ecall_wen();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
